shift_barrel_pipe: RTL and testbench

SHIFT_BARREL_PIPE -- requirements
Module: shift_barrel_pipe

---
 rtl/shift_barrel_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_shift_barrel_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_barrel_pipe.sv
// -----------------------------------------------------------------------------
// shift_barrel_pipe
//
// Pipelined barrel shifter. The log2(Bits) shift levels are distributed over
// Stages register stages (later stages take any leftover level). Each stage
// carries its own valid bit, so bubbles collapse under backpressure and a
// full pipeline holds exactly Stages operations.
//
// Handshake: a transfer happens on a port when valid and ready are both high
// at the rising edge of clk. in_ready never looks at in_valid, and out_b,
// out_tag, out_zero and out_valid hold steady while out_valid is high and
// out_ready is low.
//
// Parameters
//   Bits     data width (power of two, 8..128)
//   Stages   register stages (1..log2(Bits))
//   TagBits  width of the opaque tag returned with the result
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset, empties the pipeline
//   in_valid   operation offered
//   in_ready   operation accepted this cycle
//   in_a       operand
//   in_sh      shift amount 0..Bits-1
//   in_op      00 logical right, 01 arithmetic right, 10 logical left,
//              11 rotate right
//   in_tag     tag returned unchanged with the result
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_b      shifted result
//   out_tag    tag belonging to out_b
//   out_zero   out_b is all zeros
// -----------------------------------------------------------------------------
module shift_barrel_pipe #(
    parameter int Bits    = 64,
    parameter int Stages  = 2,
    parameter int TagBits = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Bits-1:0]         in_a,
    input  logic [$clog2(Bits)-1:0] in_sh,
    input  logic [1:0]              in_op,
    input  logic [TagBits-1:0]      in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Bits-1:0]         out_b,
    output logic [TagBits-1:0]      out_tag,
    output logic                    out_zero
);

    localparam int ShW     = $clog2(Bits);
    localparam int LvlBase = ShW / Stages;
    localparam int LvlRem  = ShW % Stages;

    localparam logic [1:0] OpLsr = 2'b00;
    localparam logic [1:0] OpAsr = 2'b01;
    localparam logic [1:0] OpLsl = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    // Number of shift levels handled by stage s; the last LvlRem stages get
    // one extra level.
    function automatic int lvl_cnt(input int s);
        return LvlBase + ((s >= Stages - LvlRem) ? 1 : 0);
    endfunction

    // Index of the first shift level handled by stage s.
    function automatic int lvl_lo(input int s);
        int acc;
        acc = 0;
        for (int j = 0; j < s; j++) begin
            acc = acc + lvl_cnt(j);
        end
        return acc;
    endfunction

    // One shift level: move d by n positions according to op. The fill bit
    // is captured once at the input (MSB of the original operand for an
    // arithmetic shift, 0 otherwise) so later stages do not need the operand.
    function automatic logic [Bits-1:0] shift_level(
        input logic [Bits-1:0] d,
        input logic [1:0]      op,
        input logic            fill,
        input int              n
    );
        logic [Bits-1:0] res;
        res = '0;
        for (int i = 0; i < Bits; i++) begin
            case (op)
                OpLsl:   res[i] = (i >= n) ? d[(i + Bits - n) % Bits] : 1'b0;
                OpRor:   res[i] = d[(i + n) % Bits];
                default: res[i] = (i + n < Bits) ? d[(i + n) % Bits] : fill;
            endcase
        end
        return res;
    endfunction

    // Stage registers
    logic [Stages-1:0]  r_valid;
    logic [Bits-1:0]    r_data [Stages];
    logic [1:0]         r_op   [Stages];
    logic               r_fill [Stages];
    logic [ShW-1:0]     r_sh   [Stages];
    logic [TagBits-1:0] r_tag  [Stages];

    // Stage inputs (from the ports for stage 0, else the previous stage)
    logic [Stages-1:0]  w_in_v;
    logic [Bits-1:0]    w_in_d   [Stages];
    logic [1:0]         w_in_op  [Stages];
    logic               w_in_fill[Stages];
    logic [ShW-1:0]     w_in_sh  [Stages];
    logic [TagBits-1:0] w_in_tag [Stages];

    // Shifted data each stage will register, and per-stage load permission
    logic [Bits-1:0]    w_nx_d   [Stages];
    logic [Stages-1:0]  w_ready;

    always_comb begin
        logic            v_rdy;
        logic [ShW-1:0]  v_mask;
        logic [Bits-1:0] v_d;

        // ready[s] = !valid[s] | ready[s+1], unrolled from the output end so
        // no signal depends on itself.
        w_ready = '0;
        v_rdy   = out_ready;
        for (int s = Stages - 1; s >= 0; s--) begin
            v_rdy      = v_rdy | ~r_valid[s];
            w_ready[s] = v_rdy;
        end

        w_in_v[0]    = in_valid;
        w_in_d[0]    = in_a;
        w_in_op[0]   = in_op;
        w_in_fill[0] = (in_op == OpAsr) & in_a[Bits-1];
        w_in_sh[0]   = in_sh;
        w_in_tag[0]  = in_tag;
        for (int s = 1; s < Stages; s++) begin
            w_in_v[s]    = r_valid[s-1];
            w_in_d[s]    = r_data[s-1];
            w_in_op[s]   = r_op[s-1];
            w_in_fill[s] = r_fill[s-1];
            w_in_sh[s]   = r_sh[s-1];
            w_in_tag[s]  = r_tag[s-1];
        end

        for (int s = 0; s < Stages; s++) begin
            v_mask = '0;
            for (int k = 0; k < ShW; k++) begin
                if (k >= lvl_lo(s) && k < lvl_lo(s) + lvl_cnt(s)) begin
                    v_mask[k] = 1'b1;
                end
            end
            v_d = w_in_d[s];
            for (int k = 0; k < ShW; k++) begin
                if (v_mask[k] && w_in_sh[s][k]) begin
                    v_d = shift_level(v_d, w_in_op[s], w_in_fill[s], 1 << k);
                end
            end
            w_nx_d[s] = v_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int s = 0; s < Stages; s++) begin
                r_data[s] <= '0;
                r_op[s]   <= OpLsr;
                r_fill[s] <= 1'b0;
                r_sh[s]   <= '0;
                r_tag[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < Stages; s++) begin
                if (w_ready[s]) begin
                    r_valid[s] <= w_in_v[s];
                end
                // Data only moves when a valid operation actually enters.
                if (w_ready[s] && w_in_v[s]) begin
                    r_data[s] <= w_nx_d[s];
                    r_op[s]   <= w_in_op[s];
                    r_fill[s] <= w_in_fill[s];
                    r_sh[s]   <= w_in_sh[s];
                    r_tag[s]  <= w_in_tag[s];
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[Stages-1];
    assign out_b     = r_data[Stages-1];
    assign out_tag   = r_tag[Stages-1];
    // Derived from the final register, so it always matches out_b.
    assign out_zero  = ~|r_data[Stages-1];

endmodule

// File: tb/tb_shift_barrel_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_barrel_pipe
//
// Bench for shift_barrel_pipe with Bits=8, Stages=3, TagBits=4. Accepted
// operations push {tag, expected result} into exp_q; a monitor on the falling
// edge pops and compares whenever the result port transfers, and checks that
// a stalled result holds still.
// -----------------------------------------------------------------------------
module tb_shift_barrel_pipe;
  localparam int W  = 8;
  localparam int ST = 3;
  localparam int TW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [2:0]    in_sh;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_b;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  shift_barrel_pipe #(.Bits(W), .Stages(ST), .TagBits(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_sh     (in_sh),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  // scoreboard state
  logic [TW+W-1:0] exp_q[$];
  logic [TW+W-1:0] exp_e;
  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  logic rnd_bp    = 1'b0;
  logic hold_pend = 1'b0;
  logic [W-1:0]  hold_b;
  logic [TW-1:0] hold_tag;

  // reference model: plain arithmetic on the whole word
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input int sh,
                                         input logic [1:0] op);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    case (op)
      2'b00:   r = a >> sh;
      2'b01:   r = W'($signed(a) >>> sh);
      2'b10:   r = a << sh;
      default: begin
        dbl = {a, a};
        r = dbl[sh +: W];
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: offer one operation, wait (bounded) for acceptance
  task automatic send(input logic [W-1:0] a, input logic [2:0] sh,
                      input logic [1:0] op, input logic [TW-1:0] tag);
    int n;
    in_a = a; in_sh = sh; in_op = op; in_tag = tag; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 2000) break;
    end
    if (in_ready) begin
      exp_q.push_back({tag, model(a, int'(sh), op)});
      accepted++;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // random backpressure
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_b", 32'(out_b), 32'(hold_b));
        chk("hold_tag", 32'(out_tag), 32'(hold_tag));
      end
      hold_pend = out_valid && !out_ready;
      hold_b    = out_b;
      hold_tag  = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_b 0x%0h tag %0d with nothing expected", out_b, out_tag);
        end else begin
          exp_e = exp_q.pop_front();
          chk("out_b", 32'(out_b), 32'(exp_e[W-1:0]));
          chk("out_tag", 32'(out_tag), 32'(exp_e[TW+W-1:W]));
          chk("out_zero", 32'(out_zero), 32'(exp_e[W-1:0] == '0));
        end
      end
    end
  end

  // watchdog
  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    int base;
    int n;
    logic [W-1:0] b2b_exp[3];
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_sh = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    b2b_exp[0] = 8'h12; b2b_exp[1] = 8'hB0; b2b_exp[2] = 8'hD2;

    // values while held in reset
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // arithmetic right, latency
    send(8'h96, 3'd3, 2'b01, 4'd5);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("asr_b", 32'(out_b), 32'hF2);
    chk("asr_tag", 32'(out_tag), 32'd5);
    chk("asr_zero", 32'(out_zero), 32'd0);
    @(posedge clk); #1;

    // back-to-back, consecutive results
    send(8'h96, 3'd3, 2'b00, 4'd1);
    send(8'h96, 3'd3, 2'b10, 4'd2);
    send(8'h96, 3'd3, 2'b11, 4'd3);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_b", 32'(out_b), 32'(b2b_exp[j]));
    end
    @(posedge clk); #1;

    // zero result and zero shift in every mode
    send(8'h01, 3'd1, 2'b00, 4'd6);
    for (int j = 0; j < 4; j++) begin
      send(8'hA5, 3'd0, 2'(j), 4'(7 + j));
    end
    repeat (6) @(posedge clk); #1;

    // full pipeline under backpressure
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          send(8'h96 + 8'(j * 17), 3'(j + 1), 2'(j), 4'(j + 11));
        end
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepted", 32'(accepted - base), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #2 chk("bp_release_ready", 32'(in_ready), 32'd1);
      end
    join
    chk("bp_all_accepted", 32'(accepted - base), 32'd4);
    repeat (8) @(posedge clk); #1;

    // reset with operations in flight
    send(8'h3C, 3'd2, 2'b00, 4'd1);
    send(8'h3C, 3'd2, 2'b10, 4'd2);
    send(8'h3C, 3'd2, 2'b11, 4'd3);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    hold_pend = 1'b0;
    #1;
    chk("inflight_rst_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_ready", 32'(in_ready), 32'd1);
    chk("inflight_rst_b", 32'(out_b), 32'd0);
    chk("inflight_rst_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    send(8'hC3, 3'd4, 2'b01, 4'd9);
    repeat (5) @(posedge clk); #1;

    // randomized operations with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom));
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
